// File: rtl/order_ref_stream_decoder_pkg.sv
// itch_decode_pkg: message-type codes, decoder FSM state encoding, record
// kind and default field sizes for the ITCH order-modify stream decoder.
package itch_decode_pkg;

  localparam logic [7:0] MSG_DELETE = 8'h44;
  localparam logic [7:0] MSG_CANCEL = 8'h58;

  localparam int DEF_REF_BYTES    = 8;
  localparam int DEF_SHARES_BYTES = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REF    = 3'd1,
    S_SHARES = 3'd2,
    S_SKIP   = 3'd3
`ifdef ORDER_DECODER_LEN_CHECK_EN
    ,
    S_DONE   = 3'd4
`endif
  } dec_state_e;

  typedef enum logic {
    KIND_DELETE = 1'b0,
    KIND_CANCEL = 1'b1
  } msg_kind_e;

  function automatic int max_bytes(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/order_ref_stream_decoder_fifo.sv
// order_msg_fifo: synchronous FIFO for decoded records. Full/empty come
// straight from the registered occupancy count so in_ready upstream never
// depends combinationally on the consumer. Head data reads as zero when empty.
module order_msg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;
  assign pop_data_o = empty_o ? '0 : mem_q[rd_q];

  // storage write; contents are don't-care until counted as occupied
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

  // pointers and occupancy count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/order_ref_stream_decoder.sv
// order_ref_stream_decoder: byte-serial decoder for ITCH Delete ('D') and
// Order Cancel ('X') messages, fields assembled MSB-first, records buffered
// in order_msg_fifo behind a valid/ready handshake.
// Optional build macro ORDER_DECODER_LEN_CHECK_EN adds the DONE state that
// flags bytes arriving after a complete message as a length overrun.
//
// state  | meaning
// IDLE   | no message open; non-sop bytes dropped
// REF    | collecting order reference bytes
// SHARES | collecting cancelled-shares bytes ('X' only)
// SKIP   | unknown type or overrun; drop until next sop
// DONE   | (len check only) message complete, waiting for sop
module order_ref_stream_decoder
  import itch_decode_pkg::*;
#(
  parameter int REF_BYTES    = DEF_REF_BYTES,
  parameter int SHARES_BYTES = DEF_SHARES_BYTES,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  input  logic                      in_sop_i,
  input  logic [7:0]                in_byte_i,
  output logic                      in_ready_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic                      out_is_cancel_o,
  output logic [8*REF_BYTES-1:0]    out_ref_o,
  output logic [8*SHARES_BYTES-1:0] out_shares_o,
  output logic                      err_pulse_o
);

  localparam int REF_W = 8 * REF_BYTES;
  localparam int SH_W  = 8 * SHARES_BYTES;
  localparam int REC_W = 1 + REF_W + SH_W;
  localparam int CNT_W = $clog2(max_bytes(REF_BYTES, SHARES_BYTES)) + 1;

  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REF_BYTES - 1);
  localparam logic [CNT_W-1:0] SH_LAST  = CNT_W'(SHARES_BYTES - 1);

  localparam logic [2:0] ST_IDLE   = S_IDLE;
  localparam logic [2:0] ST_REF    = S_REF;
  localparam logic [2:0] ST_SHARES = S_SHARES;
  localparam logic [2:0] ST_SKIP   = S_SKIP;
`ifdef ORDER_DECODER_LEN_CHECK_EN
  localparam logic [2:0] ST_DONE   = S_DONE;
  localparam logic [2:0] ST_EXIT   = ST_DONE;
`else
  localparam logic [2:0] ST_EXIT   = ST_IDLE;
`endif

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  msg_kind_e        kind_q, kind_d;
  logic [REF_W-1:0] ref_q, ref_d;
  logic [SH_W-1:0]  sh_q, sh_d;
  logic             err_q, err_d;

  logic             accept;
  logic             push;
  logic [REC_W-1:0] push_data;
  logic [REC_W-1:0] head_data;
  logic             fifo_full, fifo_empty;

  assign in_ready_o  = ~fifo_full;
  assign accept      = in_valid_i & in_ready_o;
  assign out_valid_o = ~fifo_empty;
  assign err_pulse_o = err_q;

  assign out_is_cancel_o = head_data[REC_W-1];
  assign out_ref_o       = head_data[REC_W-2 -: REF_W];
  assign out_shares_o    = head_data[SH_W-1:0];

  // next-state decode for each accepted byte; a sop always restarts decoding
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    kind_d    = kind_q;
    ref_d     = ref_q;
    sh_d      = sh_q;
    err_d     = 1'b0;
    push      = 1'b0;
    push_data = {kind_q, ref_q, sh_q};
    if (accept) begin
      if (in_sop_i) begin
        // a sop mid-field truncates the open message; the sop is still decoded
        if (state_q == ST_REF || state_q == ST_SHARES) err_d = 1'b1;
        cnt_d  = '0;
        kind_d = KIND_DELETE;
        if (in_byte_i == MSG_DELETE) begin
          state_d = ST_REF;
        end else if (in_byte_i == MSG_CANCEL) begin
          kind_d  = KIND_CANCEL;
          state_d = ST_REF;
        end else begin
          state_d = ST_SKIP;
        end
      end else begin
        case (state_q)
          ST_REF: begin
            ref_d = (ref_q << 8) | REF_W'(in_byte_i);
            if (cnt_q == REF_LAST) begin
              cnt_d = '0;
              if (kind_q == KIND_CANCEL) begin
                state_d = ST_SHARES;
              end else begin
                push      = 1'b1;
                push_data = {1'b0, ref_d, {SH_W{1'b0}}};
                state_d   = ST_EXIT;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          ST_SHARES: begin
            sh_d = (sh_q << 8) | SH_W'(in_byte_i);
            if (cnt_q == SH_LAST) begin
              cnt_d     = '0;
              push      = 1'b1;
              push_data = {1'b1, ref_q, sh_d};
              state_d   = ST_EXIT;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
`ifdef ORDER_DECODER_LEN_CHECK_EN
          ST_DONE: begin
            // byte beyond a complete message; record already pushed stays
            err_d   = 1'b1;
            state_d = ST_SKIP;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // decoder state, accumulators and error pulse register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      kind_q  <= KIND_DELETE;
      ref_q   <= '0;
      sh_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
      ref_q   <= ref_d;
      sh_q    <= sh_d;
      err_q   <= err_d;
    end
  end

  order_msg_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (out_ready_i),
    .pop_data_o  (head_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

endmodule

// File: tb/tb_order_ref_stream_decoder.sv
// Bench for order_ref_stream_decoder: directed scenarios plus randomized
// message mix, checked through an expected-record queue and a message-level
// reference model.
`timescale 1ns/1ps
module tb_order_ref_stream_decoder;

  localparam int RB    = 8;
  localparam int SB    = 4;
  localparam int REC_W = 1 + 8*RB + 8*SB;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_sop = 1'b0;
  logic [7:0]      in_byte = 8'h00;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            out_is_cancel;
  logic [8*RB-1:0] out_ref;
  logic [8*SB-1:0] out_shares;
  logic            err_pulse;

  int checks = 0;
  int failures = 0;

  logic [REC_W-1:0] exp_q[$];
  logic [7:0]       msg[$];
  bit               open_m = 0;
  bit               kind_x = 0;
  int               need = 0;
  int               err_exp = 0;
  int               err_seen = 0;
  int               bytes_acc = 0;
  bit               rand_mode = 0;

  always #5 clk = ~clk;

  order_ref_stream_decoder dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .in_valid_i      (in_valid),
    .in_sop_i        (in_sop),
    .in_byte_i       (in_byte),
    .in_ready_o      (in_ready),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_is_cancel_o (out_is_cancel),
    .out_ref_o       (out_ref),
    .out_shares_o    (out_shares),
    .err_pulse_o     (err_pulse)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model (message level) ----------------
  function automatic logic [REC_W-1:0] make_rec();
    logic [63:0] r = '0;
    logic [31:0] s = '0;
    for (int i = 0; i < RB; i++) r = r * 256 + 64'(msg[i]);
    if (kind_x) for (int i = 0; i < SB; i++) s = s * 256 + 32'(msg[RB+i]);
    return {kind_x, r, s};
  endfunction

  function automatic void model_reset();
    open_m = 0;
    msg.delete();
    exp_q.delete();
  endfunction

  function automatic void model_feed(input bit sop, input logic [7:0] b);
    if (sop) begin
      if (open_m && msg.size() < need) err_exp++;
      msg.delete();
      open_m = (b == 8'h44 || b == 8'h58);
      kind_x = (b == 8'h58);
      need   = kind_x ? RB + SB : RB;
    end else if (open_m) begin
      if (msg.size() < need) begin
        msg.push_back(b);
        if (msg.size() == need) exp_q.push_back(make_rec());
      end else begin
`ifdef ORDER_DECODER_LEN_CHECK_EN
        err_exp++;
        open_m = 0;
`endif
      end
    end
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (err_pulse) err_seen++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL record_unexpected actual=%h expected=none", {out_is_cancel, out_ref, out_shares});
        end else begin
          check("record", {out_is_cancel, out_ref, out_shares}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send_byte(input bit sop, input logic [7:0] b);
    int budget = 2000;
    if (rand_mode && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_sop   = sop;
    in_byte  = b;
    while (!in_ready && budget > 0) begin
      if (rand_mode) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      budget--;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout actual=0 expected=1");
      in_valid = 1'b0;
      return;
    end
    model_feed(sop, b);
    if (rand_mode) out_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    bytes_acc++;
    in_valid = 1'b0;
  endtask

  task automatic send_d(input logic [63:0] r);
    send_byte(1'b1, 8'h44);
    for (int i = RB-1; i >= 0; i--) send_byte(1'b0, r[8*i +: 8]);
  endtask

  task automatic send_x(input logic [63:0] r, input logic [31:0] s);
    send_byte(1'b1, 8'h58);
    for (int i = RB-1; i >= 0; i--) send_byte(1'b0, r[8*i +: 8]);
    for (int i = SB-1; i >= 0; i--) send_byte(1'b0, s[8*i +: 8]);
  endtask

  task automatic drain(input string name);
    int budget = 500;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_pending"}, 128'(exp_q.size()), 128'd0);
    check({name, "_err_count"}, 128'(err_seen), 128'(err_exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [7:0]  t;
    logic [63:0] rr;

    // reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_err_pulse", 128'(err_pulse), 128'd0);
    check("rst_is_cancel", 128'(out_is_cancel), 128'd0);
    check("rst_out_ref", 128'(out_ref), 128'd0);
    check("rst_out_shares", 128'(out_shares), 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 'D' with latency check
    out_ready = 1'b1;
    send_byte(1'b1, 8'h44);
    for (int i = 1; i <= 7; i++) send_byte(1'b0, 8'(i));
    check("d_valid_before_last", 128'(out_valid), 128'd0);
    send_byte(1'b0, 8'h08);
    check("d_valid_after_last", 128'(out_valid), 128'd1);
    check("d_ref", 128'(out_ref), 128'h0102030405060708);
    check("d_kind_shares", 128'({out_is_cancel, out_shares}), 128'd0);
    drain("delete");

    // 'X'
    base = err_seen;
    send_x(64'hAABBCCDD00112233, 32'h000003E8);
    check("x_record", 128'({out_valid, out_is_cancel, out_ref, out_shares}),
          128'({2'b11, 64'hAABBCCDD00112233, 32'h000003E8}));
    drain("cancel");
    check("x_no_err", 128'(err_seen - base), 128'd0);

    // truncation
    base = err_seen;
    send_byte(1'b1, 8'h44);
    for (int i = 0; i < 4; i++) send_byte(1'b0, 8'($urandom));
    send_x(64'h1122334455667788, 32'h00000010);
    drain("trunc");
    check("trunc_err_pulses", 128'(err_seen - base), 128'd1);

    // unknown type
    send_byte(1'b1, 8'h41);
    for (int i = 0; i < 20; i++) send_byte(1'b0, 8'($urandom));
    send_d({$urandom, $urandom});
    drain("unknown");

    // back-pressure
    out_ready = 1'b0;
    base = bytes_acc;
    fork
      begin
        for (int r = 1; r <= 5; r++) send_d(64'(r));
      end
      begin
        int budget = 200;
        while (bytes_acc < base + 36 && budget > 0) begin
          @(posedge clk); #1;
          budget--;
        end
        check("bp_in_ready_low", 128'(in_ready), 128'd0);
        check("bp_out_valid", 128'(out_valid), 128'd1);
        repeat (5) @(posedge clk);
        #1;
        check("bp_in_ready_held", 128'(in_ready), 128'd0);
        out_ready = 1'b1;
      end
    join
    drain("backpressure");

    // length overrun
    base = err_seen;
    send_d(64'hDEADBEEF00000001);
    send_byte(1'b0, 8'h11);
    send_byte(1'b0, 8'h22);
    send_d(64'h0000000000000002);
    drain("overrun");
`ifdef ORDER_DECODER_LEN_CHECK_EN
    check("overrun_err_pulses", 128'(err_seen - base), 128'd1);
`else
    check("overrun_err_pulses", 128'(err_seen - base), 128'd0);
`endif

    // reset mid-'X' with two records pending
    out_ready = 1'b0;
    send_d(64'hA);
    send_d(64'hB);
    send_byte(1'b1, 8'h58);
    for (int i = 0; i < 3; i++) send_byte(1'b0, 8'($urandom));
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check("rst_mid_out_valid", 128'(out_valid), 128'd0);
    check("rst_mid_in_ready", 128'(in_ready), 128'd1);
    rst = 1'b0;
    out_ready = 1'b1;
    send_d(64'h0123456789ABCDEF);
    drain("after_reset");

    // randomized message mix
    rand_mode = 1;
    for (int m = 0; m < 80; m++) begin
      int kind = $urandom_range(0, 9);
      int len_mode = $urandom_range(0, 5);
      int full_len;
      int n;
      if (kind < 4) t = 8'h44;
      else if (kind < 8) t = 8'h58;
      else begin
        t = 8'($urandom);
        while (t == 8'h44 || t == 8'h58) t = 8'($urandom);
      end
      full_len = (t == 8'h58) ? RB + SB : RB;
      if (len_mode == 0) n = $urandom_range(0, full_len - 1);
      else if (len_mode == 1) n = full_len + $urandom_range(1, 3);
      else n = full_len;
      send_byte(1'b1, t);
      for (int i = 0; i < n; i++) send_byte(1'b0, 8'($urandom));
    end
    rand_mode = 0;
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/order_ref_stream_decoder.md
# order_ref_stream_decoder

Streaming decoder for ITCH order-modify messages: Delete Order ('D') and Order Cancel ('X'). It consumes a byte-serial payload stream with start-of-message marking and assembles fields MSB-first. Decoded records are buffered in a small output FIFO with a valid/ready handshake. It sits between the framing layer and the order book, replacing the single-cycle, wide-payload, Delete-only decoder with a parametrised, back-pressured, multi-type generation.

## Interface
- REF_BYTES, default 8: order reference length in bytes; output width 8*REF_BYTES.
- SHARES_BYTES, default 4: cancelled-shares length in bytes ('X' only).
- FIFO_DEPTH, default 4: output FIFO entries; power of two, ≥2.
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  byte present on in_byte.
- in_sop  in  1  in_byte is message byte 0 (type byte).
- in_byte  in  8  payload byte, message order (MSB of each field first).
- in_ready  out  1  byte accepted when in_valid & in_ready.
- out_valid  out  1  FIFO head record valid.
- out_ready  in  1  consumer pops head when out_valid & out_ready.
- out_is_cancel  out  1  1 = 'X' record, 0 = 'D' record.
- out_ref  out  8*REF_BYTES  order reference number.
- out_shares  out  8*SHARES_BYTES  cancelled shares; 0 for 'D'.
- err_pulse  out  1  one-cycle pulse on a framing error.

## Operation
- FSM states: IDLE, REF, SHARES, SKIP, plus DONE when ORDER_DECODER_LEN_CHECK_EN is defined.
- Accepted sop byte, in any state: 'D' (8'h44) loads kind=D and goes to REF. 'X' (8'h58) loads kind=X and goes to REF. Any other value goes to SKIP.
- Accepted non-sop byte in IDLE or SKIP: discarded.
- REF: shift bytes into ref_acc, MSB-first; byte counter counts 0..REF_BYTES-1.
  - On the last byte, kind=D pushes {0, ref, 0} to the FIFO and exits; kind=X goes to SHARES.
- SHARES: shift SHARES_BYTES bytes into shares_acc. On the last byte, push {1, ref, shares} and exit.
- Exit state is IDLE, or DONE when the macro is defined.
- Truncation: an accepted sop while in REF or SHARES pulses err_pulse the next cycle. The partial record is discarded, and that sop byte is decoded as a new type byte in the same cycle.
- Back-pressure: in_ready = !fifo_full. Because a push only occurs on an accepted byte, a push never hits a full FIFO.
- Simultaneous push and pop on a full FIFO cannot occur, since in_ready is low. Simultaneous push and pop otherwise leaves the count unchanged.
- Accumulators are not cleared between messages; the counter and kind reset on every sop.
- Reset mid-message discards the partial record and flushes the FIFO.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, err_pulse=0, out_is_cancel=0, out_ref=0, out_shares=0.
  - FSM state is IDLE; counters and FIFO pointers are 0.
- Latency: out_valid rises 1 cycle after the final field byte is accepted. Counted from the sop byte, that is 1+REF_BYTES cycles for 'D' and 1+REF_BYTES+SHARES_BYTES cycles for 'X' at full rate.
- Throughput: 1 byte/cycle. Back-to-back messages need no idle beat.
- out_* fields are stable while out_valid=1 and out_ready=0.
- in_ready follows the registered FIFO count: low the cycle after the FIFO fills, high the cycle after a pop frees an entry.
- err_pulse is registered, one cycle wide, and asserted 1 cycle after the offending byte.

## Configuration
- ORDER_DECODER_LEN_CHECK_EN defined:
  - After a complete message the FSM waits in DONE for a sop.
  - The first accepted non-sop byte in DONE pulses err_pulse (length overrun) and moves to SKIP. The already-pushed record is kept.
- Not defined: there is no DONE state; extra bytes after a complete message are silently discarded in IDLE.

## Structure
- Package itch_decode_pkg:
  - message-type constants MSG_DELETE=8'h44 and MSG_CANCEL=8'h58;
  - FSM state enum;
  - default REF_BYTES and SHARES_BYTES.
- Sub-module order_msg_fifo: synchronous FIFO with registered count and full/empty flags. Width is 1+8*REF_BYTES+8*SHARES_BYTES; depth is FIFO_DEPTH.

## Test plan
- 'D' message: sop 8'h44, ref bytes 01..08, out_ready=1 -> one record with is_cancel=0, ref=64'h0102030405060708, shares=0; out_valid one cycle after byte 08.
- 'X' message: sop 8'h58, ref 64'hAABBCCDD00112233, shares 32'h000003E8 -> is_cancel=1 with those ref and shares values; no err_pulse.
- Truncation: 'D' plus 4 ref bytes, then sop 'X' starting a complete message -> one err_pulse; exactly one record, the 'X'.
- Unknown type 8'h41 followed by 20 bytes, then a valid 'D' -> no record for the 8'h41 message; the 'D' record is correct.
- Back-pressure: out_ready=0 while 5 'D' messages with refs 1..5 are sent (FIFO_DEPTH=4) -> in_ready drops after the 4th push. Then raise out_ready -> records pop in order 1..5 with no loss.
- Macro on: a complete 'D' followed by 2 extra bytes and then a sop -> record delivered, exactly one err_pulse. Macro off: no err_pulse.
- Reset mid-'X' with 2 FIFO entries pending -> out_valid=0 and in_ready=1 the cycle after reset; a following 'D' decodes correctly.
